// File: rtl/stream_to_onchip_writer_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : stream_to_onchip_writer_pkg
// Purpose  : Shared types and constants for the stream-to-on-chip-RAM writer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package stream_to_onchip_writer_pkg;

  localparam int unsigned C_DEPTH_DEFAULT  = 97500;
  localparam int unsigned C_ADDR_W_DEFAULT = 17;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_WRITE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Nibble k holds the byteenable for empty=k; byte 0 sits at bits 7:0.
  localparam logic [15:0] C_BE_MAP = {4'h1, 4'h3, 4'h7, 4'hF};

  function automatic logic [3:0] be_from_empty(input logic [1:0] empty);
    return C_BE_MAP[{empty, 2'b00} +: 4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_to_onchip_writer_addr_wrap.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : onchip_addr_wrap
// Purpose  : (base + offset) mod DEPTH for operands already below DEPTH.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module onchip_addr_wrap #(
  parameter int unsigned DEPTH  = 97500,
  parameter int unsigned ADDR_W = 17
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W:0]   C_DEPTH_WIDE   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] C_DEPTH_NARROW = ADDR_W'(DEPTH);

  logic [ADDR_W:0]   w_sum;
  logic [ADDR_W-1:0] w_sub;

  assign w_sum = {1'b0, base} + {1'b0, offset};
  // The wrapped result is below DEPTH, so modular ADDR_W arithmetic is exact.
  assign w_sub = base + offset - C_DEPTH_NARROW;
  assign addr  = (w_sum >= C_DEPTH_WIDE) ? w_sub : w_sum[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: rtl/stream_to_onchip_writer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : stream_to_onchip_writer
// Purpose  : Captures one Avalon-ST packet into a single-port on-chip RAM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module stream_to_onchip_writer
  import stream_to_onchip_writer_pkg::*;
#(
  parameter int unsigned DEPTH  = C_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W = C_ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] max_words,
  input  logic [31:0]       snk_data,
  input  logic              snk_valid,
  input  logic              snk_sop,
  input  logic              snk_eop,
  input  logic [1:0]        snk_empty,
  output logic              snk_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              busy,
  output logic              done,
  output logic              truncated,
  output logic [ADDR_W-1:0] word_count
);

  state_t            r_state;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_trunc;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_data;
  logic [3:0]        r_mem_be;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_limit;
  logic [ADDR_W-1:0] r_word_count;

  logic              w_accept;
  logic              w_write;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_count_next;
  logic [ADDR_W-1:0] w_limit_in;
  logic [3:0]        w_be;

  onchip_addr_wrap #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_addr_wrap (
    .base   (r_base),
    .offset (r_word_count),
    .addr   (w_addr)
  );

  assign w_accept     = snk_valid & r_ready;
  assign w_write      = w_accept & ~abort &
                        (((r_state == ST_ARMED) & snk_sop) | (r_state == ST_WRITE));
  assign w_count_next = r_word_count + ADDR_W'(1);
  assign w_last       = (w_count_next == r_limit);
  assign w_limit_in   = (max_words == '0) ? ADDR_W'(DEPTH) : max_words;
  assign w_be         = snk_eop ? be_from_empty(snk_empty) : 4'hF;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_trunc      <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_mem_be     <= '0;
      r_base       <= '0;
      r_limit      <= '0;
      r_word_count <= '0;
    end else begin
      r_mem_write <= w_write;
      r_done      <= 1'b0;

      if (w_write) begin
        r_mem_addr   <= w_addr;
        r_mem_data   <= snk_data;
        r_mem_be     <= w_be;
        r_word_count <= w_count_next;
      end

      if (abort) begin
        r_state <= ST_IDLE;
        r_ready <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state      <= ST_ARMED;
              r_ready      <= 1'b1;
              r_busy       <= 1'b1;
              r_trunc      <= 1'b0;
              r_word_count <= '0;
              r_base       <= base_addr;
              r_limit      <= w_limit_in;
            end
          end
          ST_ARMED, ST_WRITE: begin
            // eop takes priority over the limit: a full packet is not truncated.
            if (w_write) begin
              if (snk_eop) begin
                r_state <= ST_DONE;
                r_ready <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else if (w_last) begin
                r_state <= ST_DRAIN;
                r_trunc <= 1'b1;
              end else begin
                r_state <= ST_WRITE;
              end
            end
          end
          ST_DRAIN: begin
            if (w_accept && snk_eop) begin
              r_state <= ST_DONE;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign snk_ready      = r_ready;
  assign busy           = r_busy;
  assign done           = r_done;
  assign truncated      = r_trunc;
  assign word_count     = r_word_count;
  assign mem_write      = r_mem_write;
  assign mem_chipselect = r_mem_write;
  assign mem_address    = r_mem_addr;
  assign mem_writedata  = r_mem_data;
  assign mem_byteenable = r_mem_be;

endmodule
`default_nettype wire
